// File: rtl/sdram_word_port_if.sv
// Bundle of the CPU word-request port and the SDRAM controller halfword port.
// slave = word-port view, master = CPU plus controller environment.
interface sdram_word_port_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [22:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        busy;

   logic        sdram_wr_req;
   logic        sdram_rd_req;
   logic        sdram_wr_ack;
   logic        sdram_rd_ack;
   logic [23:0] sdram_wr_addr;
   logic [23:0] sdram_rd_addr;
   logic [9:0]  sdram_wr_burst;
   logic [9:0]  sdram_rd_burst;
   logic [15:0] sdram_din;
   logic [15:0] sdram_dout;
   logic        sdram_init_done;
   logic        about_to_refresh;
   logic        idle;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ready, busy,
      output sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr,
      output sdram_wr_burst, sdram_rd_burst, sdram_din,
      input  sdram_wr_ack, sdram_rd_ack, sdram_dout,
      input  sdram_init_done, about_to_refresh, idle
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ready, busy,
      input  sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr,
      input  sdram_wr_burst, sdram_rd_burst, sdram_din,
      output sdram_wr_ack, sdram_rd_ack, sdram_dout,
      output sdram_init_done, about_to_refresh, idle
   );
endinterface

// File: rtl/sdram_word_port.sv
// Splits 32-bit CPU word accesses into two 16-bit SDRAM controller beats.
//   state  | meaning
//   S_IDLE | waiting for cpu_req, busy=0
//   S_WAIT | request latched, waiting for controller ready and no pending refresh
//   S_REQ  | wr/rd request held until the first ack (beat 0)
//   S_XFER | request dropped, waiting for the beat 1 ack
//   S_DONE | one-cycle cpu_ready, back to idle next
module sdram_word_port #(
   parameter int BURST_LEN = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   sdram_word_port_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_REQ,
      S_XFER,
      S_DONE
   } state_t;

   state_t      state;
   logic        we_q;
   logic [22:0] addr_q;
   logic [31:0] wdata_q;
   logic        beat;
   logic [15:0] rbuf;
   logic [31:0] rdata_q;
   logic        busy_q;
   logic        ready_q;
   logic        wr_req_q;
   logic        rd_req_q;
   logic        ack;
   logic        sdram_ok;

   // Only the ack matching the latched direction is ever looked at.
   assign ack      = we_q ? bus.sdram_wr_ack : bus.sdram_rd_ack;
   assign sdram_ok = bus.sdram_init_done && bus.idle && !bus.about_to_refresh;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         beat     <= 1'b0;
         rbuf     <= '0;
         rdata_q  <= '0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b0;
         wr_req_q <= 1'b0;
         rd_req_q <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.cpu_req) begin
                  we_q    <= bus.cpu_we;
                  addr_q  <= bus.cpu_addr;
                  wdata_q <= bus.cpu_wdata;
                  beat    <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (sdram_ok) begin
                  wr_req_q <= we_q;
                  rd_req_q <= !we_q;
                  state    <= S_REQ;
               end
            end
            S_REQ: begin
               // Refresh warnings are no longer honoured once the request is out.
               if (ack) begin
                  wr_req_q <= 1'b0;
                  rd_req_q <= 1'b0;
                  if (!we_q) rbuf <= bus.sdram_dout;
                  beat  <= 1'b1;
                  state <= S_XFER;
               end
            end
            S_XFER: begin
               if (ack) begin
                  if (!we_q) rdata_q <= {bus.sdram_dout, rbuf};
                  beat    <= 1'b0;
                  ready_q <= 1'b1;
                  state   <= S_DONE;
               end
            end
            S_DONE: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.cpu_rdata      = rdata_q;
   assign bus.cpu_ready      = ready_q;
   assign bus.busy           = busy_q;
   assign bus.sdram_wr_req   = wr_req_q;
   assign bus.sdram_rd_req   = rd_req_q;
   assign bus.sdram_wr_addr  = {addr_q, 1'b0};
   assign bus.sdram_rd_addr  = {addr_q, 1'b0};
   assign bus.sdram_wr_burst = 10'(BURST_LEN);
   assign bus.sdram_rd_burst = 10'(BURST_LEN);
   // Beat data must be valid in the same cycle as its ack.
   assign bus.sdram_din      = beat ? wdata_q[31:16] : wdata_q[15:0];

endmodule

// File: tb/tb_sdram_word_port.sv
// Directed bench for sdram_word_port: the bench acts as CPU and as a registered
// SDRAM controller that acks one cycle after it sees a request.
module tb_sdram_word_port;

   logic clk;
   logic rst_n;
   sdram_word_port_if bus ();

   sdram_word_port #(.BURST_LEN(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int txn_starts = 0;
   logic req_prev = 1'b0;

   typedef struct {
      logic        we;
      logic [22:0] addr;
      logic [31:0] wdata;
      logic [15:0] d0;
      logic [15:0] d1;
      int          gap;
      logic        stray;
      logic [23:0] exp_addr;
      logic [15:0] exp_din0;
      logic [15:0] exp_din1;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t tbl[4];

   function automatic vec_t mk(input logic we, input logic [22:0] addr, input logic [31:0] wdata,
                               input logic [15:0] d0, input logic [15:0] d1, input int gap,
                               input logic stray, input logic [23:0] exp_addr,
                               input logic [15:0] exp_din0, input logic [15:0] exp_din1,
                               input logic [31:0] exp_rdata);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.d0 = d0; v.d1 = d1; v.gap = gap;
      v.stray = stray; v.exp_addr = exp_addr; v.exp_din0 = exp_din0; v.exp_din1 = exp_din1;
      v.exp_rdata = exp_rdata;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if ((bus.sdram_wr_req || bus.sdram_rd_req) && !req_prev) txn_starts++;
      req_prev = bus.sdram_wr_req || bus.sdram_rd_req;
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"},     bus.busy, 1'b0);
      chk({tag, "_ready"},    bus.cpu_ready, 1'b0);
      chk({tag, "_reqs"},     {bus.sdram_wr_req, bus.sdram_rd_req}, 2'b00);
      chk({tag, "_wr_addr"},  bus.sdram_wr_addr, 24'h0);
      chk({tag, "_rd_addr"},  bus.sdram_rd_addr, 24'h0);
      chk({tag, "_din"},      bus.sdram_din, 16'h0);
      chk({tag, "_rdata"},    bus.cpu_rdata, 32'h0);
      chk({tag, "_wr_burst"}, bus.sdram_wr_burst, 10'd2);
      chk({tag, "_rd_burst"}, bus.sdram_rd_burst, 10'd2);
   endtask

   task automatic set_acks(input logic we, input logic match, input logic other);
      bus.sdram_wr_ack = we ? match : other;
      bus.sdram_rd_ack = we ? other : match;
   endtask

   // One full word transaction; req_cyc is the number of cycles until a request is seen.
   task automatic run_txn(input vec_t v, input bit chk_lat, output int req_cyc);
      int  cnt;
      bit  seen;
      cnt = 0;
      seen = 0;
      req_cyc = 0;
      @(negedge clk);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = v.we;
      bus.cpu_addr  = v.addr;
      bus.cpu_wdata = v.wdata;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         cnt++;
         if (i == 0) bus.cpu_req = 1'b0;
         if (bus.sdram_wr_req || bus.sdram_rd_req) seen = 1;
         else begin
            // Acks in WAIT must be ignored.
            bus.sdram_wr_ack = v.stray;
            bus.sdram_rd_ack = v.stray;
         end
      end
      bus.sdram_wr_ack = 1'b0;
      bus.sdram_rd_ack = 1'b0;
      chk("req_seen", 32'(seen), 32'd1);
      if (!seen) return;
      req_cyc = cnt;
      chk("req_dir",   {bus.sdram_wr_req, bus.sdram_rd_req}, v.we ? 2'b10 : 2'b01);
      chk("req_addr",  v.we ? bus.sdram_wr_addr : bus.sdram_rd_addr, v.exp_addr);
      chk("busy_wait", bus.busy, 1'b1);

      @(negedge clk);
      cnt++;
      chk("req_held", bus.sdram_wr_req | bus.sdram_rd_req, 1'b1);
      set_acks(v.we, 1'b1, v.stray);
      bus.sdram_dout = v.d0;
      if (v.we) chk("din_beat0", bus.sdram_din, v.exp_din0);

      @(negedge clk);
      cnt++;
      chk("req_drop",  {bus.sdram_wr_req, bus.sdram_rd_req}, 2'b00);
      chk("xfer_addr", v.we ? bus.sdram_wr_addr : bus.sdram_rd_addr, v.exp_addr);
      for (int g = 0; g < v.gap; g++) begin
         set_acks(v.we, 1'b0, v.stray);
         bus.sdram_dout = 16'h0BAD;
         @(negedge clk);
         cnt++;
         chk("gap_no_ready", bus.cpu_ready, 1'b0);
      end
      set_acks(v.we, 1'b1, v.stray);
      bus.sdram_dout = v.d1;
      if (v.we) chk("din_beat1", bus.sdram_din, v.exp_din1);

      @(negedge clk);
      cnt++;
      set_acks(v.we, 1'b0, v.stray);
      bus.sdram_dout = 16'h0BAD;
      chk("ready",     bus.cpu_ready, 1'b1);
      chk("busy_done", bus.busy, 1'b1);
      chk("rdata",     bus.cpu_rdata, v.exp_rdata);
      if (chk_lat) chk("latency", cnt, 5);

      @(negedge clk);
      set_acks(v.we, 1'b0, 1'b0);
      chk("ready_pulse", bus.cpu_ready, 1'b0);
      chk("busy_idle",   bus.busy, 1'b0);
      chk("rdata_hold",  bus.cpu_rdata, v.exp_rdata);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   rc;
      int   viol;
      int   starts0;
      vec_t v;
      bit   seen;

      rst_n = 1'b0;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.sdram_wr_ack = 1'b0; bus.sdram_rd_ack = 1'b0; bus.sdram_dout = '0;
      bus.sdram_init_done = 1'b1; bus.about_to_refresh = 1'b0; bus.idle = 1'b1;

      //          we    addr        wdata         d0       d1       gap str exp_addr     din0     din1     rdata
      tbl[0] = mk(1'b1, 23'h000010, 32'hDEADBEEF, 16'h0,   16'h0,   0, 0, 24'h000020, 16'hBEEF, 16'hDEAD, 32'h00000000);
      tbl[1] = mk(1'b0, 23'h000010, 32'h0,        16'h1234, 16'hABCD, 1, 0, 24'h000020, 16'h0,   16'h0,   32'hABCD1234);
      tbl[2] = mk(1'b1, 23'h7FFFFF, 32'h0000FFFF, 16'h0,   16'h0,   2, 1, 24'hFFFFFE, 16'hFFFF, 16'h0000, 32'hABCD1234);
      tbl[3] = mk(1'b0, 23'h000000, 32'h0,        16'h5A5A, 16'hA5A5, 0, 0, 24'h000000, 16'h0,   16'h0,   32'hA5A55A5A);

      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         run_txn(tbl[i], tbl[i].gap == 0, rc);
      end

      // Gating: init_done low 100 cycles, then refresh pending 10, then idle low 5.
      v = mk(1'b1, 23'h000100, 32'h13572468, 16'h0, 16'h0, 0, 0, 24'h000200, 16'h2468, 16'h1357, 32'hA5A55A5A);
      bus.sdram_init_done = 1'b0;
      viol = 0;
      fork
         run_txn(v, 1'b0, rc);
         begin
            @(negedge clk);
            for (int i = 1; i <= 115; i++) begin
               @(negedge clk);
               if (bus.sdram_wr_req || bus.sdram_rd_req) viol++;
               if (i == 100) begin bus.sdram_init_done = 1'b1; bus.about_to_refresh = 1'b1; end
               if (i == 110) begin bus.about_to_refresh = 1'b0; bus.idle = 1'b0; end
               if (i == 115) bus.idle = 1'b1;
            end
         end
      join
      chk("gate_no_req", viol, 0);
      chk("gate_req_cycle", rc, 116);

      // Overlap: a second request while busy is dropped.
      starts0 = txn_starts;
      v = mk(1'b0, 23'h000020, 32'h0, 16'h1111, 16'h2222, 0, 0, 24'h000040, 16'h0, 16'h0, 32'h22221111);
      fork
         run_txn(v, 1'b1, rc);
         begin
            repeat (3) @(negedge clk);
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 23'h3FFFFF;
            repeat (3) @(negedge clk);
            bus.cpu_req = 1'b0;
         end
      join
      repeat (20) @(negedge clk);
      chk("overlap_one_txn", txn_starts - starts0, 1);
      chk("overlap_idle", bus.busy, 1'b0);

      // Reset in XFER after beat 0.
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 23'h000040; bus.cpu_wdata = 32'hCAFEF00D;
      @(negedge clk);
      bus.cpu_req = 1'b0;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (bus.sdram_wr_req) seen = 1;
         else @(negedge clk);
      end
      chk("abort_req_seen", 32'(seen), 32'd1);
      @(negedge clk);
      bus.sdram_wr_ack = 1'b1;
      @(negedge clk);
      bus.sdram_wr_ack = 1'b0;
      chk("abort_din_beat1", bus.sdram_din, 16'hCAFE);
      #2 rst_n = 1'b0;
      #1 chk_reset("abort");
      viol = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.cpu_ready) viol++;
      end
      chk("abort_no_ready", viol, 0);
      rst_n = 1'b1;

      v = mk(1'b0, 23'h000001, 32'h0, 16'h0F0F, 16'hF0F0, 0, 0, 24'h000002, 16'h0, 16'h0, 32'hF0F00F0F);
      run_txn(v, 1'b1, rc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sdram_word_port.md
SDRAM_WORD_PORT -- requirements
Module: sdram_word_port

Interface
REQ-001 Parameter: BURST_LEN, default 2, halfword beats per CPU word; this revision supports only the value 2.
REQ-002 clk  in  1  system clock, 100 MHz, same clock as the SDRAM controller.
REQ-003 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 cpu_req  in  1  CPU access request; sampled only while busy=0.
REQ-005 cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
REQ-006 cpu_addr  in  23  word address.
REQ-007 cpu_wdata  in  32  write data.
REQ-008 cpu_rdata  out  32  read data; valid when cpu_ready=1 for a read.
REQ-009 cpu_ready  out  1  single-cycle completion pulse.
REQ-010 busy  out  1  high from acceptance until cpu_ready, inclusive.
REQ-011 sdram_wr_req / sdram_rd_req  out  1 each  requests to the controller.
REQ-012 sdram_wr_ack / sdram_rd_ack  in  1 each  per-beat acknowledges from the controller.
REQ-013 sdram_wr_addr / sdram_rd_addr  out  24 each  halfword address.
REQ-014 sdram_wr_burst / sdram_rd_burst  out  10 each  constant BURST_LEN.
REQ-015 sdram_din  out  16  write beat data.
REQ-016 sdram_dout  in  16  read beat data.
REQ-017 sdram_init_done, about_to_refresh, idle  in  1 each  controller status.

Function
REQ-018 FSM states: IDLE, WAIT, REQ, XFER, DONE.
REQ-019 IDLE: on cpu_req=1, latch cpu_we, cpu_addr and cpu_wdata, set busy=1 and go to WAIT; a cpu_req arriving while busy=1 is ignored and is not queued.
REQ-020 WAIT: go to REQ in the first cycle with sdram_init_done=1, idle=1 and about_to_refresh=0; otherwise stay in WAIT.
REQ-021 REQ: assert sdram_wr_req (write) or sdram_rd_req (read), never both, and hold it until the first cycle the matching ack=1.
REQ-022 The request is deasserted in the cycle after the first ack and the FSM enters XFER; that first ack cycle counts as beat 0.
REQ-023 sdram_wr_addr and sdram_rd_addr equal {latched addr, 1'b0} from REQ through XFER.
REQ-024 Write data mapping: beat 0 carries wdata[15:0] and beat 1 carries wdata[31:16].
REQ-025 sdram_din is combinationally selected by the beat counter, so it is valid in the same cycle as each ack=1.
REQ-026 Read data capture: on each rd_ack=1 cycle, sdram_dout is stored into rdata[16*k +: 16], where k is the beat counter.
REQ-027 Beat counter: 1 bit, advanced only on cycles with ack=1; ack gaps (ack=0) are tolerated and stall the counter.
REQ-028 After beat 1 is acked, the FSM goes to DONE.
REQ-029 Acks arriving in IDLE, in WAIT, or for the non-requested direction are ignored.
REQ-030 DONE lasts one cycle: cpu_ready=1, cpu_rdata is stable, and the next state is IDLE with busy=0 in the following cycle.
REQ-031 cpu_rdata holds its value until the next read completes.
REQ-032 Minimum latency, from the cpu_req sample to cpu_ready, is 5 cycles when all status inputs are ready and ack returns immediately.
REQ-033 If about_to_refresh rises while in REQ, the request stays asserted; back-off applies only in WAIT.

Reset
REQ-034 On rst_n=0, asynchronously: state=IDLE, busy=0, cpu_ready=0, sdram_wr_req=0, sdram_rd_req=0.
REQ-035 On rst_n=0, asynchronously: beat counter=0, cpu_rdata=0, latched registers=0, both address outputs=0, sdram_din=0.
REQ-036 Reset asserted mid-transfer aborts the transfer: no cpu_ready is produced, and the controller is expected to be reset simultaneously.
REQ-037 After reset, sdram_wr_burst and sdram_rd_burst read BURST_LEN.

Verification
REQ-038 Write: cpu_addr=0x000010 with wdata 0xDEADBEEF and immediate acks -> wr_addr=0x000020, din beats 0xBEEF then 0xDEAD, cpu_ready 5 cycles after the request.
REQ-039 Read: same address, controller returns 0x1234 then 0xABCD with a 1-cycle ack gap -> cpu_rdata=0xABCD1234 and exactly one cpu_ready pulse.
REQ-040 Gating: sdram_init_done=0 for 100 cycles, then about_to_refresh=1 for 10 cycles -> no sdram_*_req until both conditions clear.
REQ-041 Overlap: a second cpu_req issued while busy=1 -> ignored, with exactly one transaction on the controller side.
REQ-042 Reset during XFER after beat 0 -> all outputs return to reset values and no cpu_ready; the next request completes normally.
REQ-043 Stray acks: sdram_rd_ack=1 pulses during a write -> no effect on the beat count or on cpu_rdata.
